// File: rtl/handshake_defs.sv
`default_nettype none
// ============================================================================
// Module   : handshake_defs
// Brief    : State encodings shared by the handshake responder and initiator.
// Revision : 1.0 - initial release
// ============================================================================
package handshake_defs;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] VALID = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_VALID = VALID,
        ST_ACK   = ACK
    } state_t;

endpackage
`default_nettype wire

// File: rtl/handshake_responder_sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Brief    : Multi-flop single-bit synchronizer with synchronous reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/handshake_responder.sv
`default_nettype none
// ============================================================================
// Module   : handshake_responder
// Brief    : Receive side of a 4-phase req/ack CDC handshake with ready/valid out.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_responder
    import handshake_defs::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_req,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ready,
    output logic                  out_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_busy,
    output logic [CNT_WIDTH-1:0]  out_xfer_count
);

    logic                  req_s;
    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_req_sync (
        .clk_i (in_clk),
        .rst_i (in_reset),
        .d_i   (in_req),
        .q_o   (req_s)
    );

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // in_data is only trusted once req_s proves the initiator holds it stable
                if (req_s) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (valid_q && in_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_ack        = ack_q;
    assign out_valid      = valid_q;
    assign out_data       = data_q;
    assign out_xfer_count = cnt_q;
    assign out_busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_handshake_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_responder
// Brief    : Self-checking bench: vector table, directed corners, random CDC run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_responder;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          in_clk;
    logic          in_reset;
    logic          in_req;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_busy;
    logic [CW-1:0] out_xfer_count;

    logic          ini_clk;
    int            ini_half;
    logic          ini_done;

    int            n_cmp;
    int            n_bad;
    logic [DW-1:0] sent_q[$];
    int            consumed;
    int            model_total;
    int            ack_idle_viol;

    handshake_responder #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .in_clk         (in_clk),
        .in_reset       (in_reset),
        .in_req         (in_req),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_ack        (out_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_busy       (out_busy),
        .out_xfer_count (out_xfer_count)
    );

    initial in_clk = 1'b0;
    always #15 in_clk = ~in_clk;

    // Initiator clock is offset so its edges never coincide with in_clk edges
    initial begin
        ini_clk = 1'b0;
        #2;
        forever #(ini_half) ini_clk = ~ini_clk;
    end

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          rdy;
        logic          valid;
        logic          ack;
        logic          busy;
        logic [DW-1:0] odata;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge in_clk);
        in_reset = 1'b1;
        in_req   = 1'b0;
        in_ready = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        in_reset = 1'b0;
    endtask

    // Counts edges until the chosen output (0=valid, 1=ack) reaches lvl
    task automatic wait_for(input int sel, input logic lvl, output int edges);
        logic cur;
        edges = 0;
        do begin
            @(posedge in_clk);
            #1;
            edges++;
            cur = (sel == 0) ? out_valid : out_ack;
        end while (cur !== lvl && edges < 60);
    endtask

    task automatic xfer(input logic [DW-1:0] d);
        int e;
        @(negedge in_clk);
        in_data  = d;
        in_req   = 1'b1;
        in_ready = 1'b1;
        wait_for(1, 1'b1, e);
        if (out_ack !== 1'b1) chk("xfer_ack_rise", {31'd0, out_ack}, 32'd1);
        @(negedge in_clk);
        in_req = 1'b0;
        wait_for(1, 1'b0, e);
        if (out_ack !== 1'b0) chk("xfer_ack_fall", {31'd0, out_ack}, 32'd0);
    endtask

    task automatic run_initiator(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            @(posedge ini_clk);
            in_data = DW'($urandom);
            sent_q.push_back(in_data);
            @(posedge ini_clk);
            in_req = 1'b1;
            guard = 0;
            while (!out_ack && guard < 300) begin
                @(posedge ini_clk);
                guard++;
            end
            if (!out_ack) begin
                chk("rnd_ack_timeout", {31'd0, out_ack}, 32'd1);
                break;
            end
            in_req = 1'b0;
            guard = 0;
            while (out_ack && guard < 300) begin
                @(posedge ini_clk);
                guard++;
            end
            if (out_ack) begin
                chk("rnd_ack_stuck", {31'd0, out_ack}, 32'd0);
                break;
            end
        end
        ini_done = 1'b1;
    endtask

    task automatic run_monitor();
        logic [DW-1:0] exp;
        while (!ini_done) begin
            @(negedge in_clk);
            in_ready = ($urandom_range(3) != 0);
            if (out_ack && !out_busy) ack_idle_viol++;
            if (out_valid && in_ready) begin
                if (sent_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_dup: got extra word %0h expected none", out_data);
                end else begin
                    exp = sent_q.pop_front();
                    chk("sb_data", {24'd0, out_data}, {24'd0, exp});
                end
                consumed++;
                model_total++;
            end
        end
    endtask

    task automatic random_phase(input int half, input int n);
        ini_half      = half;
        ini_done      = 1'b0;
        consumed      = 0;
        ack_idle_viol = 0;
        fork
            run_initiator(n);
            run_monitor();
        join
        repeat (4) @(posedge in_clk);
        #1;
        chk("rnd_leftover", sent_q.size(), 32'd0);
        chk("rnd_consumed", consumed, n);
        chk("rnd_ack_idle", ack_idle_viol, 32'd0);
        chk("rnd_count", {28'd0, out_xfer_count}, model_total % (1 << CW));
        sent_q.delete();
    endtask

    initial begin
        int e;
        n_cmp       = 0;
        n_bad       = 0;
        model_total = 0;
        ini_half    = 45;
        ini_done    = 1'b0;
        in_reset    = 1'b1;
        in_req      = 1'b0;
        in_ready    = 1'b0;
        in_data     = '0;

        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd0};
        tbl[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1};
        tbl[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1};
        tbl[5]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1};
        tbl[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd1};
        tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd1};
        tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd1};
        tbl[9]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd1};
        tbl[10] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd2};
        tbl[11] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd2};
        tbl[12] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd2};
        tbl[13] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd2};

        reset_dut();
        #1;
        chk("reset_state", {17'd0, out_valid, out_ack, out_busy, out_data, out_xfer_count}, 32'd0);

        // Basic transfer, one-cycle valid, teardown latency and second word
        for (int i = 0; i < 14; i++) begin
            @(negedge in_clk);
            in_req   = tbl[i].req;
            in_data  = tbl[i].data;
            in_ready = tbl[i].rdy;
            @(posedge in_clk);
            #1;
            chk($sformatf("vec[%0d]", i),
                {17'd0, out_valid, out_ack, out_busy, out_data, out_xfer_count},
                {17'd0, tbl[i].valid, tbl[i].ack, tbl[i].busy, tbl[i].odata, tbl[i].cnt});
        end

        // Backpressure: word held while ready is low
        reset_dut();
        @(negedge in_clk);
        in_data  = 8'h3C;
        in_req   = 1'b1;
        in_ready = 1'b0;
        wait_for(0, 1'b1, e);
        chk("bp_latency", e, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge in_clk);
            #1;
            chk($sformatf("bp_hold[%0d]", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h3C});
        end
        @(negedge in_clk);
        in_ready = 1'b1;
        @(posedge in_clk);
        #1;
        chk("bp_ack", {28'd0, out_ack, out_valid, out_busy, 1'b0} | {28'd0, out_xfer_count},
            {28'd0, 4'b1010} | 32'd1);
        @(negedge in_clk);
        in_req   = 1'b0;
        in_ready = 1'b0;
        wait_for(1, 1'b0, e);
        chk("bp_teardown", {e[29:0], out_busy, out_ack}, {30'd3, 1'b0, 1'b0});

        // Reset while VALID with in_req still asserted
        reset_dut();
        @(negedge in_clk);
        in_data = 8'h77;
        in_req  = 1'b1;
        wait_for(0, 1'b1, e);
        chk("rst_first_valid", e, 32'd3);
        @(negedge in_clk);
        in_reset = 1'b1;
        @(posedge in_clk);
        #1;
        chk("rst_clear", {17'd0, out_valid, out_ack, out_busy, out_data, out_xfer_count}, 32'd0);
        @(negedge in_clk);
        in_reset = 1'b0;
        wait_for(0, 1'b1, e);
        chk("rst_repeat_latency", e, 32'd3);
        chk("rst_repeat_data", {24'd0, out_data}, 32'h77);
        @(negedge in_clk);
        in_ready = 1'b1;
        @(posedge in_clk);
        #1;
        chk("rst_repeat_count", {27'd0, out_ack, out_xfer_count}, {27'd0, 1'b1, 4'd1});
        @(negedge in_clk);
        in_req = 1'b0;
        wait_for(1, 1'b0, e);

        // Counter wrap over a 4-bit counter
        reset_dut();
        for (int i = 0; i < 17; i++) xfer(8'(i * 7 + 3));
        chk("wrap_count", {28'd0, out_xfer_count}, 32'd1);
        chk("wrap_last_data", {24'd0, out_data}, 32'd115);

        // Random asynchronous runs: slow then fast initiator
        reset_dut();
        model_total = 0;
        random_phase(45, 1000);
        random_phase(5, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
